// File: rtl/strand_sequencer_if.sv
// strand_sequencer_if -- bundle between the strand sequencer and its host.
//
// Carries the frame request, the per-strand config write port, the pixel
// descriptor stream to the address generator, and status/debug signals.
//
// Descriptor handshake: the sequencer (master) raises out_valid together with
// a descriptor; a beat transfers on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the descriptor
// fields hold unchanged. out_valid never depends combinationally on out_ready.
//
// Modports:
//   master -- the sequencer: drives descriptor/status, receives control/config
//   slave  -- the host/consumer side
interface strand_sequencer_if #(
  parameter int STRAND_BITS = 3,
  parameter int IDX_WIDTH   = 11
);
  logic                   frame_start;
  logic                   cfg_we;
  logic [1:0]             cfg_sel;
  logic [STRAND_BITS-1:0] cfg_strand;
  logic [IDX_WIDTH-1:0]   cfg_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [STRAND_BITS-1:0] out_strand;
  logic [IDX_WIDTH-1:0]   out_idx;
  logic [IDX_WIDTH-1:0]   out_offset;
  logic [IDX_WIDTH-1:0]   out_length;
  logic                   out_last;

  logic                   busy;
  logic                   frame_done;
  logic                   frame_overrun;
  logic [1:0]             dbg_state;  // FSM state: 0 IDLE, 1 LOAD, 2 RUN, 3 DONE

  modport master (
    input  frame_start, cfg_we, cfg_sel, cfg_strand, cfg_data, out_ready,
    output out_valid, out_strand, out_idx, out_offset, out_length, out_last,
           busy, frame_done, frame_overrun, dbg_state
  );

  modport slave (
    output frame_start, cfg_we, cfg_sel, cfg_strand, cfg_data, out_ready,
    input  out_valid, out_strand, out_idx, out_offset, out_length, out_last,
           busy, frame_done, frame_overrun, dbg_state
  );
endinterface

// File: rtl/strand_sequencer.sv
// strand_sequencer -- walks every LED strand once per frame and emits one
// pixel descriptor (strand, index, offset, length, last) per pixel.
//
// Ports:
//   clk    -- single clock, rising edge
//   rst_n  -- synchronous active-low reset
//   bus    -- strand_sequencer_if.master: frame_start, config write port
//             (cfg_we/cfg_sel/cfg_strand/cfg_data), descriptor stream
//             (out_valid/out_ready/out_*), busy, frame_done, frame_overrun,
//             dbg_state
//
// Per-strand length/offset/step registers are written at any time. Length and
// offset are latched when a strand is loaded, so writes during a frame only
// affect strands not yet loaded. At frame end every non-empty strand's offset
// scrolls by its step, wrapping modulo its length.
module strand_sequencer #(
  parameter int NUM_STRANDS = 8,
  parameter int STRAND_BITS = 3,
  parameter int IDX_WIDTH   = 11
) (
  input logic                clk,
  input logic                rst_n,
  strand_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [STRAND_BITS-1:0] LAST_STRAND = STRAND_BITS'(NUM_STRANDS - 1);

  state_t                 state_q;
  logic [STRAND_BITS-1:0] strand_q;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic [IDX_WIDTH-1:0]   off_lat_q;
  logic [IDX_WIDTH-1:0]   len_lat_q;
  logic                   valid_q;
  logic                   last_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ovr_q;

  logic [IDX_WIDTH-1:0]   len_q  [NUM_STRANDS];
  logic [IDX_WIDTH-1:0]   off_q  [NUM_STRANDS];
  logic [IDX_WIDTH-1:0]   step_q [NUM_STRANDS];

  logic [IDX_WIDTH:0]     sum_d  [NUM_STRANDS];
  logic [IDX_WIDTH-1:0]   off_scroll_d [NUM_STRANDS];
  logic                   cfg_hit;

  // Writes aimed past the last strand are dropped.
  assign cfg_hit = bus.cfg_we && (32'(bus.cfg_strand) < NUM_STRANDS);

  // Scrolled offset: one extra bit so offset+step cannot wrap before the
  // compare against length. Empty strands keep their offset.
  always_comb begin
    for (int i = 0; i < NUM_STRANDS; i++) begin
      sum_d[i] = {1'b0, off_q[i]} + {1'b0, step_q[i]};
      if (len_q[i] == '0) begin
        off_scroll_d[i] = off_q[i];
      end else if (sum_d[i] >= {1'b0, len_q[i]}) begin
        off_scroll_d[i] = IDX_WIDTH'(sum_d[i] - {1'b0, len_q[i]});
      end else begin
        off_scroll_d[i] = sum_d[i][IDX_WIDTH-1:0];
      end
    end
  end

  // Config registers. The config write comes after the scroll update so a
  // same-cycle offset write in DONE wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STRANDS; i++) begin
        len_q[i]  <= '0;
        off_q[i]  <= '0;
        step_q[i] <= '0;
      end
    end else begin
      if (state_q == S_DONE) begin
        for (int i = 0; i < NUM_STRANDS; i++) begin
          off_q[i] <= off_scroll_d[i];
        end
      end
      if (cfg_hit) begin
        case (bus.cfg_sel)
          2'd0:    len_q[bus.cfg_strand]  <= bus.cfg_data;
          2'd1:    off_q[bus.cfg_strand]  <= bus.cfg_data;
          2'd2:    step_q[bus.cfg_strand] <= bus.cfg_data;
          default: ;
        endcase
      end
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      strand_q  <= '0;
      idx_q     <= '0;
      off_lat_q <= '0;
      len_lat_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A start request outside IDLE (including DONE) is dropped and flagged.
      ovr_q  <= bus.frame_start && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (bus.frame_start) begin
            state_q  <= S_LOAD;
            strand_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        S_LOAD: begin
          len_lat_q <= len_q[strand_q];
          off_lat_q <= off_q[strand_q];
          idx_q     <= '0;
          last_q    <= (len_q[strand_q] == IDX_WIDTH'(1));
          if (len_q[strand_q] == '0) begin
            if (strand_q == LAST_STRAND) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              strand_q <= strand_q + 1'b1;
            end
          end else begin
            state_q <= S_RUN;
            valid_q <= 1'b1;
          end
        end
        S_RUN: begin
          // valid_q is 1 for the whole of RUN, so out_ready alone accepts.
          if (bus.out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              if (strand_q == LAST_STRAND) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                strand_q <= strand_q + 1'b1;
                state_q  <= S_LOAD;
              end
            end else begin
              idx_q  <= idx_q + 1'b1;
              // Next index is idx+1; it is last when idx+1 == length-1.
              last_q <= ((idx_q + IDX_WIDTH'(2)) == len_lat_q);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_strand    = strand_q;
  assign bus.out_idx       = idx_q;
  assign bus.out_offset    = off_lat_q;
  assign bus.out_length    = len_lat_q;
  assign bus.out_last      = last_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_overrun = ovr_q;
  assign bus.dbg_state     = state_q;

endmodule
